// File: rtl/core_mem_port_arbiter_pkg.sv
// Shared types and constants for the core memory-port arbiter.
// Owner encoding for the response-steering tag FIFO, the packed request
// payload held in the output register, and the fixed operand values that an
// instruction fetch presents on the memory port.
package core_mem_port_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] INST_ORDER = 2'b10;
  localparam logic       INST_RW    = 1'b1;

  typedef struct packed {
    logic [1:0]  order;
    logic        rw;
    logic [13:0] tid;
    logic [1:0]  mmumod;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  // A fetch is always a read with fixed ORDER, no TID and no write data.
  function automatic mem_req_t inst_req(input logic [1:0]  mmumod,
                                        input logic [31:0] pdt,
                                        input logic [31:0] addr);
    mem_req_t r;
    r.order  = INST_ORDER;
    r.rw     = INST_RW;
    r.tid    = '0;
    r.mmumod = mmumod;
    r.pdt    = pdt;
    r.addr   = addr;
    r.data   = '0;
    return r;
  endfunction

endpackage

// File: rtl/core_mem_arb_tag_fifo.sv
// In-order owner-tag FIFO: one bit per accepted memory request recording who
// issued it, so each in-order response can be steered back to its requester.
// The arbiter's credit check guarantees no push when full and pops are gated
// by empty, so no overflow/underflow protection is needed here.
module core_mem_arb_tag_fifo #(
  parameter int OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         push_owner_i,
  input  logic                         pop_i,
  output logic [$clog2(OUTSTANDING):0] count_o,
  output logic                         empty_o,
  output logic                         head_o
);

  localparam int PW = $clog2(OUTSTANDING);

  logic          mem_q [OUTSTANDING];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_owner_i;
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/core_mem_port_arbiter.sv
// Shares the single L1/MMU memory port between instruction fetch and
// load/store. A registered arbitration stage (DATA priority with an INST
// anti-starvation override) feeds the memory port; an owner-tag FIFO steers
// in-order responses back combinationally.
module core_mem_port_arbiter
  import core_mem_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iINST_REQ,
  output logic        oINST_LOCK,
  input  logic [1:0]  iINST_MMUMOD,
  input  logic [31:0] iINST_PDT,
  input  logic [31:0] iINST_ADDR,
  output logic        oINST_VALID,
  output logic        oINST_PAGEFAULT,
  output logic [63:0] oINST_DATA,
  output logic [27:0] oINST_MMU_FLAGS,
  input  logic        iDATA_REQ,
  output logic        oDATA_LOCK,
  input  logic [1:0]  iDATA_ORDER,
  input  logic        iDATA_RW,
  input  logic [13:0] iDATA_TID,
  input  logic [1:0]  iDATA_MMUMOD,
  input  logic [31:0] iDATA_PDT,
  input  logic [31:0] iDATA_ADDR,
  input  logic [31:0] iDATA_DATA,
  output logic        oDATA_VALID,
  output logic        oDATA_PAGEFAULT,
  output logic [63:0] oDATA_DATA,
  output logic [27:0] oDATA_MMU_FLAGS,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic [1:0]  oMEM_ORDER,
  output logic        oMEM_RW,
  output logic [13:0] oMEM_TID,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [31:0] oMEM_PDT,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic        iMEM_PAGEFAULT,
  input  logic [63:0] iMEM_DATA,
  input  logic [27:0] iMEM_MMU_FLAGS,
  output logic        oERR_UNEXPECTED
);

  localparam int             CW         = $clog2(OUTSTANDING) + 1;
  localparam logic [CW:0]    CREDIT_LIM = (CW+1)'(OUTSTANDING);
  localparam logic [3:0]     STARVE_MAX = 4'(STARVE_LIMIT);

  logic          mem_req_q, mem_req_d;
  mem_req_t      req_q, req_d;
  owner_e        owner_q, owner_d;
  logic [3:0]    starve_q, starve_d;
  logic          err_q, err_d;

  logic [CW-1:0] tag_count;
  logic          tag_empty;
  logic          tag_head;

  logic          accept, out_free, pop, credit, arb_ok;
  logic          grant_inst, grant_data, rsp_ok;
  logic [CW:0]   inflight;

  // Arbitration: output register free, tag credit left, then DATA unless INST is starved.
  always_comb begin
    accept     = mem_req_q && !iMEM_LOCK;
    out_free   = !mem_req_q || accept;
    pop        = iMEM_VALID && !tag_empty;
    // The request sitting in the output register already owns a tag slot.
    inflight   = {1'b0, tag_count} + {{CW{1'b0}}, mem_req_q} - {{CW{1'b0}}, pop};
    credit     = (inflight < CREDIT_LIM);
    arb_ok     = !iRESET_SYNC && out_free && credit;
    grant_data = arb_ok && iDATA_REQ && !(iINST_REQ && (starve_q == STARVE_MAX));
    grant_inst = arb_ok && iINST_REQ && !grant_data;
    oINST_LOCK = !grant_inst;
    oDATA_LOCK = !grant_data;
  end

  // Output register next state: load the winner, otherwise hold while stalled.
  always_comb begin
    mem_req_d = mem_req_q;
    req_d     = req_q;
    owner_d   = owner_q;
    if (out_free) begin
      mem_req_d = grant_data || grant_inst;
      if (grant_data) begin
        req_d.order  = iDATA_ORDER;
        req_d.rw     = iDATA_RW;
        req_d.tid    = iDATA_TID;
        req_d.mmumod = iDATA_MMUMOD;
        req_d.pdt    = iDATA_PDT;
        req_d.addr   = iDATA_ADDR;
        req_d.data   = iDATA_DATA;
        owner_d      = OWNER_DATA;
      end else if (grant_inst) begin
        req_d   = inst_req(iINST_MMUMOD, iINST_PDT, iINST_ADDR);
        owner_d = OWNER_INST;
      end
    end
  end

  // Starvation counter and sticky unexpected-response flag next state.
  always_comb begin
    starve_d = starve_q;
    if (!iINST_REQ || grant_inst) begin
      starve_d = '0;
    end else if (grant_data && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
    err_d = err_q || (iMEM_VALID && tag_empty);
  end

  // State registers; reset drops any pending memory request.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      mem_req_q <= 1'b0;
      req_q     <= '0;
      owner_q   <= OWNER_INST;
      starve_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      mem_req_q <= mem_req_d;
      req_q     <= req_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      err_q     <= err_d;
    end
  end

  core_mem_arb_tag_fifo #(
    .OUTSTANDING (OUTSTANDING)
  ) u_tag_fifo (
    .clk_i        (iCLOCK),
    .rst_i        (iRESET_SYNC),
    .push_i       (accept),
    .push_owner_i (owner_q),
    .pop_i        (pop),
    .count_o      (tag_count),
    .empty_o      (tag_empty),
    .head_o       (tag_head)
  );

  // Response steering by FIFO head; payload forced to zero when not strobed.
  always_comb begin
    rsp_ok          = iMEM_VALID && !tag_empty && !iRESET_SYNC;
    oINST_VALID     = rsp_ok && (tag_head == OWNER_INST);
    oDATA_VALID     = rsp_ok && (tag_head == OWNER_DATA);
    oINST_PAGEFAULT = oINST_VALID ? iMEM_PAGEFAULT : 1'b0;
    oINST_DATA      = oINST_VALID ? iMEM_DATA      : '0;
    oINST_MMU_FLAGS = oINST_VALID ? iMEM_MMU_FLAGS : '0;
    oDATA_PAGEFAULT = oDATA_VALID ? iMEM_PAGEFAULT : 1'b0;
    oDATA_DATA      = oDATA_VALID ? iMEM_DATA      : '0;
    oDATA_MMU_FLAGS = oDATA_VALID ? iMEM_MMU_FLAGS : '0;
  end

  assign oMEM_REQ        = mem_req_q;
  assign oMEM_ORDER      = req_q.order;
  assign oMEM_RW         = req_q.rw;
  assign oMEM_TID        = req_q.tid;
  assign oMEM_MMUMOD     = req_q.mmumod;
  assign oMEM_PDT        = req_q.pdt;
  assign oMEM_ADDR       = req_q.addr;
  assign oMEM_DATA       = req_q.data;
  assign oERR_UNEXPECTED = err_q;

endmodule

// File: tb/tb_core_mem_port_arbiter.sv
// Scoreboard bench for core_mem_port_arbiter: expected memory requests and
// responses are queued as stimulus is driven, and compared as the DUT
// accepts requests and strobes responses.
module tb_core_mem_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iINST_REQ, iDATA_REQ, iMEM_LOCK, iMEM_VALID, iMEM_PAGEFAULT, iDATA_RW;
  logic [1:0]  iINST_MMUMOD, iDATA_ORDER, iDATA_MMUMOD;
  logic [31:0] iINST_PDT, iINST_ADDR, iDATA_PDT, iDATA_ADDR, iDATA_DATA;
  logic [13:0] iDATA_TID;
  logic [63:0] iMEM_DATA;
  logic [27:0] iMEM_MMU_FLAGS;

  logic        oINST_LOCK, oINST_VALID, oINST_PAGEFAULT;
  logic [63:0] oINST_DATA, oDATA_DATA;
  logic [27:0] oINST_MMU_FLAGS, oDATA_MMU_FLAGS;
  logic        oDATA_LOCK, oDATA_VALID, oDATA_PAGEFAULT;
  logic        oMEM_REQ, oMEM_RW, oERR_UNEXPECTED;
  logic [1:0]  oMEM_ORDER, oMEM_MMUMOD;
  logic [13:0] oMEM_TID;
  logic [31:0] oMEM_PDT, oMEM_ADDR, oMEM_DATA;

  core_mem_port_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst),
    .iINST_REQ(iINST_REQ), .oINST_LOCK(oINST_LOCK),
    .iINST_MMUMOD(iINST_MMUMOD), .iINST_PDT(iINST_PDT), .iINST_ADDR(iINST_ADDR),
    .oINST_VALID(oINST_VALID), .oINST_PAGEFAULT(oINST_PAGEFAULT),
    .oINST_DATA(oINST_DATA), .oINST_MMU_FLAGS(oINST_MMU_FLAGS),
    .iDATA_REQ(iDATA_REQ), .oDATA_LOCK(oDATA_LOCK),
    .iDATA_ORDER(iDATA_ORDER), .iDATA_RW(iDATA_RW), .iDATA_TID(iDATA_TID),
    .iDATA_MMUMOD(iDATA_MMUMOD), .iDATA_PDT(iDATA_PDT), .iDATA_ADDR(iDATA_ADDR),
    .iDATA_DATA(iDATA_DATA),
    .oDATA_VALID(oDATA_VALID), .oDATA_PAGEFAULT(oDATA_PAGEFAULT),
    .oDATA_DATA(oDATA_DATA), .oDATA_MMU_FLAGS(oDATA_MMU_FLAGS),
    .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(iMEM_LOCK),
    .oMEM_ORDER(oMEM_ORDER), .oMEM_RW(oMEM_RW), .oMEM_TID(oMEM_TID),
    .oMEM_MMUMOD(oMEM_MMUMOD), .oMEM_PDT(oMEM_PDT), .oMEM_ADDR(oMEM_ADDR),
    .oMEM_DATA(oMEM_DATA),
    .iMEM_VALID(iMEM_VALID), .iMEM_PAGEFAULT(iMEM_PAGEFAULT),
    .iMEM_DATA(iMEM_DATA), .iMEM_MMU_FLAGS(iMEM_MMU_FLAGS),
    .oERR_UNEXPECTED(oERR_UNEXPECTED)
  );

  typedef struct {
    logic        owner;
    logic [1:0]  order;
    logic        rw;
    logic [13:0] tid;
    logic [1:0]  mmumod;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [63:0] data;
    logic [27:0] flags;
    logic        pf;
  } rsp_t;

  req_t        exp_req[$];
  rsp_t        exp_rsp[$];
  logic        tag_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        exp_err;
  int          d_left, d_idx, i_left, i_idx;
  logic [31:0] d_base, i_base;
  logic        d_rw;
  logic        auto_rsp, man_vld, man_pf;
  logic [63:0] man_data;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk_d(input int k);
    req_t r;
    r.owner  = 1'b1;
    r.order  = 2'b01;
    r.rw     = d_rw;
    r.tid    = 14'(32'h55 + k);
    r.mmumod = 2'b01;
    r.pdt    = 32'h1000;
    r.addr   = d_base + 32'(4 * k);
    r.data   = r.addr ^ 32'hA5A5_A5A5;
    return r;
  endfunction

  // Expected memory-side view of a fetch: fixed ORDER/RW, zero TID and data.
  function automatic req_t mk_i(input int k);
    req_t r;
    r.owner  = 1'b0;
    r.order  = 2'b10;
    r.rw     = 1'b1;
    r.tid    = 14'h0;
    r.mmumod = 2'b11;
    r.pdt    = 32'h2000;
    r.addr   = i_base + 32'(4 * k);
    r.data   = 32'h0;
    return r;
  endfunction

  task automatic drive();
    req_t r;
    if (d_left > 0) begin
      r = mk_d(d_idx);
      iDATA_REQ = 1'b1; iDATA_ORDER = r.order; iDATA_RW = r.rw; iDATA_TID = r.tid;
      iDATA_MMUMOD = r.mmumod; iDATA_PDT = r.pdt; iDATA_ADDR = r.addr; iDATA_DATA = r.data;
    end else begin
      iDATA_REQ = 1'b0;
    end
    if (i_left > 0) begin
      iINST_REQ = 1'b1; iINST_MMUMOD = 2'b11; iINST_PDT = 32'h2000;
      iINST_ADDR = i_base + 32'(4 * i_idx);
    end else begin
      iINST_REQ = 1'b0;
    end
    if (auto_rsp) begin
      iMEM_VALID = (tag_q.size() > 0);
      iMEM_DATA = {$urandom, $urandom};
      iMEM_MMU_FLAGS = 28'($urandom);
      iMEM_PAGEFAULT = 1'b0;
    end else begin
      iMEM_VALID = man_vld;
      iMEM_DATA = man_data;
      iMEM_MMU_FLAGS = man_data[27:0] ^ 28'h0F0F0F0;
      iMEM_PAGEFAULT = man_pf;
    end
    if (iMEM_VALID && !rst) exp_rsp.push_back('{iMEM_DATA, iMEM_MMU_FLAGS, iMEM_PAGEFAULT});
  endtask

  task automatic observe();
    req_t e;
    rsp_t r;
    logic own;
    if (rst) return;
    chk_eq("err_flag", oERR_UNEXPECTED, exp_err);
    // Responses pop the old head before a same-cycle accept pushes.
    if (iMEM_VALID) begin
      r = exp_rsp.pop_front();
      if (tag_q.size() == 0) begin
        chk_eq("unexp_strobe", {oINST_VALID, oDATA_VALID}, 0);
        exp_err = 1'b1;
      end else begin
        own = tag_q.pop_front();
        chk_eq("rsp_inst_vld", oINST_VALID, !own);
        chk_eq("rsp_data_vld", oDATA_VALID, own);
        if (own) begin
          chk_eq("rsp_data_payload", oDATA_DATA, r.data);
          chk_eq("rsp_data_pf_flags", {oDATA_PAGEFAULT, oDATA_MMU_FLAGS}, {r.pf, r.flags});
          chk_eq("rsp_inst_zero", oINST_DATA, 0);
        end else begin
          chk_eq("rsp_inst_payload", oINST_DATA, r.data);
          chk_eq("rsp_inst_pf_flags", {oINST_PAGEFAULT, oINST_MMU_FLAGS}, {r.pf, r.flags});
          chk_eq("rsp_data_zero", oDATA_DATA, 0);
        end
      end
    end else begin
      chk_eq("idle_strobe", {oINST_VALID, oDATA_VALID}, 0);
      chk_eq("idle_payload", oINST_DATA | oDATA_DATA, 0);
    end
    if (oMEM_REQ && !iMEM_LOCK) begin
      if (exp_req.size() == 0) begin
        chk_eq("spurious_req", oMEM_REQ, 0);
      end else begin
        e = exp_req.pop_front();
        chk_eq("req_addr", oMEM_ADDR, e.addr);
        chk_eq("req_ctl", {oMEM_ORDER, oMEM_RW, oMEM_TID, oMEM_MMUMOD},
               {e.order, e.rw, e.tid, e.mmumod});
        chk_eq("req_pdt_data", {oMEM_PDT, oMEM_DATA}, {e.pdt, e.data});
        tag_q.push_back(e.owner);
      end
    end
  endtask

  task automatic advance();
    if (rst) return;
    if (iDATA_REQ && !oDATA_LOCK) begin d_idx++; d_left--; end
    if (iINST_REQ && !oINST_LOCK) begin i_idx++; i_left--; end
  endtask

  task automatic pre();
    drive();
    @(negedge clk);
  endtask

  task automatic post();
    observe();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_req.delete(); exp_rsp.delete(); tag_q.delete();
    d_left = 0; i_left = 0; d_idx = 0; i_idx = 0;
    man_vld = 1'b0; auto_rsp = 1'b0;
    cycle();
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic drain(input string tag);
    auto_rsp = 1'b1;
    man_vld = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (d_left == 0 && i_left == 0 && tag_q.size() == 0 && exp_req.size() == 0 && !oMEM_REQ) break;
      cycle();
    end
    chk_eq(tag, 64'(d_left + i_left + tag_q.size() + exp_req.size()), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    iINST_REQ = 0; iDATA_REQ = 0; iMEM_LOCK = 0; iMEM_VALID = 0; iMEM_PAGEFAULT = 0;
    iDATA_RW = 0; iINST_MMUMOD = 0; iDATA_ORDER = 0; iDATA_MMUMOD = 0;
    iINST_PDT = 0; iINST_ADDR = 0; iDATA_PDT = 0; iDATA_ADDR = 0; iDATA_DATA = 0;
    iDATA_TID = 0; iMEM_DATA = 0; iMEM_MMU_FLAGS = 0;
    d_base = 32'h100; i_base = 32'h200; d_rw = 1'b1;
    d_left = 0; i_left = 0; d_idx = 0; i_idx = 0;
    auto_rsp = 0; man_vld = 0; man_pf = 0; man_data = 0; exp_err = 0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset holds both requesters locked and suppresses strobes.
    d_left = 1; i_left = 1; man_vld = 1'b1; man_data = 64'h1234;
    pre();
    chk_eq("rst_lock", {oINST_LOCK, oDATA_LOCK}, 2'b11);
    chk_eq("rst_strobe", {oINST_VALID, oDATA_VALID}, 0);
    chk_eq("rst_mem", {oMEM_REQ, oMEM_ADDR}, 0);
    chk_eq("rst_err", oERR_UNEXPECTED, 0);
    post();
    do_reset();

    // Single DATA read and its same-cycle response.
    d_base = 32'h100; d_rw = 1'b1; d_idx = 0; d_left = 1;
    exp_req.push_back(mk_d(0));
    pre();
    chk_eq("t1_grant", oDATA_LOCK, 0);
    post();
    chk_eq("t1_memreq", {oMEM_REQ, oMEM_RW}, 2'b11);
    chk_eq("t1_addr", oMEM_ADDR, 32'h100);
    chk_eq("t1_tid", oMEM_TID, 14'h55);
    cycle();
    man_vld = 1'b1; man_data = 64'hDEAD; man_pf = 1'b0;
    pre();
    chk_eq("t1_rsp", {oDATA_VALID, oINST_VALID}, 2'b10);
    chk_eq("t1_rsp_data", oDATA_DATA, 64'hDEAD);
    post();
    man_vld = 1'b0;
    drain("t1_drain");

    // Both held continuously: grant order D,D,D,D,I,D,D,D,D,I.
    d_base = 32'h1000; i_base = 32'h2000; d_rw = 1'b0;
    d_idx = 0; i_idx = 0; d_left = 8; i_left = 2;
    for (int k = 0; k < 4; k++) exp_req.push_back(mk_d(k));
    exp_req.push_back(mk_i(0));
    for (int k = 4; k < 8; k++) exp_req.push_back(mk_d(k));
    exp_req.push_back(mk_i(1));
    drain("starve_drain");

    // Memory stall: outputs stable, both locked, accept and regrant on release.
    iMEM_LOCK = 1'b1;
    d_base = 32'h300; i_base = 32'h400; d_rw = 1'b1;
    d_idx = 0; i_idx = 0; d_left = 2; i_left = 1;
    exp_req.push_back(mk_d(0)); exp_req.push_back(mk_d(1)); exp_req.push_back(mk_i(0));
    auto_rsp = 1'b1;
    cycle();
    for (int k = 0; k < 5; k++) begin
      pre();
      chk_eq("stall_lock", {oINST_LOCK, oDATA_LOCK}, 2'b11);
      chk_eq("stall_req", {oMEM_REQ, oMEM_ADDR}, {1'b1, 32'h300});
      post();
    end
    iMEM_LOCK = 1'b0;
    pre();
    chk_eq("unlock_regrant", oDATA_LOCK, 0);
    post();
    drain("stall_drain");

    // Credit: four outstanding blocks the fifth until one response returns.
    auto_rsp = 1'b0; man_vld = 1'b0;
    d_base = 32'h500; d_idx = 0; d_left = 5;
    for (int k = 0; k < 5; k++) exp_req.push_back(mk_d(k));
    repeat (6) cycle();
    pre();
    chk_eq("credit_full_lock", oDATA_LOCK, 1);
    post();
    man_vld = 1'b1; man_data = 64'h5555_0000_AAAA; man_pf = 1'b0;
    pre();
    chk_eq("credit_release", oDATA_LOCK, 0);
    post();
    man_vld = 1'b0;
    drain("credit_drain");

    // I, D, I issued; responses steered in order with a fault on the second.
    auto_rsp = 1'b0;
    i_base = 32'h600; i_idx = 0; i_left = 1; exp_req.push_back(mk_i(0));
    cycle();
    d_base = 32'h700; d_idx = 0; d_left = 1; d_rw = 1'b1; exp_req.push_back(mk_d(0));
    cycle();
    i_base = 32'h604; i_idx = 0; i_left = 1; exp_req.push_back(mk_i(0));
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) begin
      man_vld = 1'b1; man_data = 64'h1111_2222_3333_0000 + 64'(k); man_pf = (k == 1);
      pre();
      if (k == 1) chk_eq("pf_second", {oDATA_VALID, oDATA_PAGEFAULT, oINST_VALID}, 3'b110);
      else chk_eq("inst_rsp_order", {oINST_VALID, oDATA_VALID}, 2'b10);
      post();
    end
    man_vld = 1'b0;
    drain("order_drain");

    // Reset with a stalled request pending drops it.
    iMEM_LOCK = 1'b1;
    d_base = 32'h800; d_idx = 0; d_left = 1; exp_req.push_back(mk_d(0));
    cycle();
    chk_eq("pending_before_rst", oMEM_REQ, 1);
    do_reset();
    chk_eq("rst_midop_req", oMEM_REQ, 0);
    iMEM_LOCK = 1'b0;
    cycle();

    // Response with no outstanding tag: no strobe, sticky error until reset.
    man_vld = 1'b1; man_data = 64'hBAD; man_pf = 1'b0;
    pre();
    chk_eq("unexp_no_strobe", {oINST_VALID, oDATA_VALID}, 0);
    post();
    man_vld = 1'b0;
    cycle();
    pre();
    chk_eq("err_sticky", oERR_UNEXPECTED, 1);
    post();
    do_reset();
    chk_eq("err_cleared", oERR_UNEXPECTED, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
